// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline.
//
// Contents:
//   XLEN, REG_AW  - datapath width and register index width
//   REG_ZERO      - index of the hardwired-zero register x0
//   fwd_sel_t     - operand source chosen by the forwarding mux
//   reg_match()   - "this producer writes the register this consumer reads"
//
// Optional feature macro used by users of this package: WB_BYPASS_EN.
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic [2:0] {
    FWD_RF,
    FWD_EX,
    FWD_MEM,
    FWD_WB,
    FWD_ZERO
  } fwd_sel_t;

  // A write to x0 is discarded by the regfile, so it must never forward.
  function automatic logic reg_match(input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] rd,
                                     input logic              we);
    return we && (rd != REG_ZERO) && (rd == rs);
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Forwarding mux for a single source operand.
//
// Picks the operand value by priority: x0 -> 0, then the youngest in-flight
// producer (EX, MEM, WB), then the regfile read data. Also flags when the
// operand cannot be supplied this cycle.
//
// Ports:
//   rs, use_rs               source index and "instruction really reads it"
//   ex_rd/ex_we/ex_is_load   producer in EX (load data not ready yet)
//   ex_data                  EX result
//   mem_rd/mem_we/mem_data   producer in MEM
//   wb_rd/wb_we/wb_data      producer in WB
//   rf_data                  regfile read data for rs
//   value                    resolved operand
//   hazard                   operand not available, stall the instruction
//
// Macro WB_BYPASS_EN: when defined the WB result is forwarded; otherwise an
// operand that would need it stalls until the regfile write has landed.
module operand_fwd_mux
  import cpu_pkg::*;
(
  input  logic [REG_AW-1:0] rs,
  input  logic              use_rs,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_we,
  input  logic              ex_is_load,
  input  logic [XLEN-1:0]   ex_data,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_we,
  input  logic [XLEN-1:0]   mem_data,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_we,
  input  logic [XLEN-1:0]   wb_data,
  input  logic [XLEN-1:0]   rf_data,
  output logic [XLEN-1:0]   value,
  output logic              hazard
);

  logic     rs_zero;
  logic     ex_hit;
  logic     mem_hit;
  logic     wb_hit;
  logic     load_use;
  logic     wb_wait;
  fwd_sel_t sel;

  always_comb begin
    rs_zero = (rs == REG_ZERO);
    ex_hit  = reg_match(rs, ex_rd, ex_we);
    mem_hit = reg_match(rs, mem_rd, mem_we);
    wb_hit  = reg_match(rs, wb_rd, wb_we);
  end

  always_comb begin
    sel = FWD_RF;
    if (rs_zero) begin
      sel = FWD_ZERO;
    end else if (ex_hit) begin
      sel = FWD_EX;
    end else if (mem_hit) begin
      sel = FWD_MEM;
`ifdef WB_BYPASS_EN
    end else if (wb_hit) begin
      sel = FWD_WB;
`endif
    end
  end

  always_comb begin
    value = rf_data;
    unique case (sel)
      FWD_ZERO: value = '0;
      FWD_EX:   value = ex_data;
      FWD_MEM:  value = mem_data;
      FWD_WB:   value = wb_data;
      FWD_RF:   value = rf_data;
      default:  value = rf_data;
    endcase
  end

  // ex_hit already implies rs != x0, since a match requires rd != x0.
  always_comb begin
    load_use = use_rs && ex_hit && ex_is_load;
`ifdef WB_BYPASS_EN
    wb_wait  = 1'b0;
`else
    // Without the WB path the regfile still holds the stale value; wait only
    // when WB would actually have been the selected source.
    wb_wait  = use_rs && wb_hit && !ex_hit && !mem_hit;
`endif
    hazard   = load_use || wb_wait;
  end

endmodule

// File: rtl/operand_read_stage.sv
// Operand read stage between decode and execute.
//
// Drives the regfile read addresses, resolves both source operands through
// EX/MEM/WB forwarding, stalls on load-use hazards and holds the operand
// pipeline register toward EX under a valid/ready handshake.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               squash the held and the incoming instruction
//   in_*                decoded instruction and its handshake (in_ready out)
//   rf_rs1/rf_rs2       regfile read addresses (combinational)
//   rf_rv1/rf_rv2       regfile read data (same cycle)
//   ex_*/mem_*/wb_*     downstream producers used for forwarding
//   out_*               operand register toward EX and its handshake
//
// Macro WB_BYPASS_EN: enables forwarding from WB (default: stall instead).
module operand_read_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_rd_we,
  input  logic              in_is_load,

  output logic [REG_AW-1:0] rf_rs1,
  output logic [REG_AW-1:0] rf_rs2,
  input  logic [XLEN-1:0]   rf_rv1,
  input  logic [XLEN-1:0]   rf_rv2,

  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              ex_we,
  input  logic              mem_we,
  input  logic              wb_we,
  input  logic              ex_is_load,
  input  logic [XLEN-1:0]   ex_data,
  input  logic [XLEN-1:0]   mem_data,
  input  logic [XLEN-1:0]   wb_data,

  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_rd_we,
  output logic              out_is_load
);

  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            hazard1;
  logic            hazard2;
  logic            hazard;
  logic            advance;
  logic            accept;

  assign rf_rs1 = in_rs1;
  assign rf_rs2 = in_rs2;

  operand_fwd_mux u_fwd_rs1 (
    .rs         (in_rs1),
    .use_rs     (in_use_rs1),
    .ex_rd      (ex_rd),
    .ex_we      (ex_we),
    .ex_is_load (ex_is_load),
    .ex_data    (ex_data),
    .mem_rd     (mem_rd),
    .mem_we     (mem_we),
    .mem_data   (mem_data),
    .wb_rd      (wb_rd),
    .wb_we      (wb_we),
    .wb_data    (wb_data),
    .rf_data    (rf_rv1),
    .value      (op1),
    .hazard     (hazard1)
  );

  operand_fwd_mux u_fwd_rs2 (
    .rs         (in_rs2),
    .use_rs     (in_use_rs2),
    .ex_rd      (ex_rd),
    .ex_we      (ex_we),
    .ex_is_load (ex_is_load),
    .ex_data    (ex_data),
    .mem_rd     (mem_rd),
    .mem_we     (mem_we),
    .mem_data   (mem_data),
    .wb_rd      (wb_rd),
    .wb_we      (wb_we),
    .wb_data    (wb_data),
    .rf_data    (rf_rv2),
    .value      (op2),
    .hazard     (hazard2)
  );

  always_comb begin
    hazard   = hazard1 || hazard2;
    advance  = !out_valid || out_ready;
    in_ready = advance && !hazard && !flush && !rst;
    accept   = in_valid && in_ready;
  end

  // Payload only changes on accept, so a held or flushed slot keeps its
  // last contents; out_valid alone says whether they mean anything.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_rd      <= '0;
      out_rd_we   <= 1'b0;
      out_is_load <= 1'b0;
    end else if (flush) begin
      out_valid   <= 1'b0;
    end else if (advance) begin
      out_valid   <= accept;
      if (accept) begin
        out_pc      <= in_pc;
        out_op1     <= op1;
        out_op2     <= op2;
        out_rd      <= in_rd;
        out_rd_we   <= in_rd_we;
        out_is_load <= in_is_load;
      end
    end
  end

endmodule
